// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and iteration count for the HI/LO multiply-divide unit
package muldiv_pkg;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_DIV   = 3'b110;
  localparam logic [2:0] OP_DIVU  = 3'b111;
  localparam int ITER_CNT = 32;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic s);
    return s ? -v : v;
  endfunction
endpackage

// File: rtl/muldiv_iter_step.sv
// muldiv_iter_step: one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step
// Divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_iter_step
  import muldiv_pkg::*;
(
  input  logic        div,
  input  logic [63:0] acc,
  input  logic [31:0] mag,
  input  logic        bit_in,
  output logic [63:0] acc_next
);
  logic [32:0] sum;
  assign sum = {1'b0, acc[63:32]} + (bit_in ? {1'b0, mag} : 33'd0);
`ifdef MULDIV_DIV_EN
  // acc = {remainder, quotient}; bit_in is the next dividend bit, msb first
  logic [33:0] diff;
  assign diff = {1'b0, acc[63:32], bit_in} - {2'b0, mag};
  assign acc_next = div ? {(diff[33] ? {acc[62:32], bit_in} : diff[31:0]), acc[30:0], ~diff[33]}
                        : {sum, acc[31:1]};
`else
  logic unused_div;
  assign unused_div = div;
  assign acc_next = {sum, acc[31:1]};
`endif
endmodule

// File: rtl/hi_lo_muldiv_seq.sv
// hi_lo_muldiv_seq: iterative MIPS-style HI/LO multiply/divide unit, 34-cycle latency
// Division is compiled in only when MULDIV_DIV_EN is defined.
module hi_lo_muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        ReadReq,
  input  logic        ReadSel,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);
  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [63:0] acc, acc_step, prod, mul_res, res;
  logic [31:0] op_a, op_b;
  logic [2:0]  op;
  logic        sa, sb, sgn, go_mul, go_div, div_st, step_bit;
  assign sgn    = Op != OP_MULTU && Op != OP_DIVU;
  assign go_mul = Start && !Op[2];
`ifdef MULDIV_DIV_EN
  assign go_div   = Start && Op[2:1] == 2'b11;
  assign div_st   = state == S_DIV;
  assign step_bit = div_st ? op_a[~cnt] : op_b[cnt];
`else
  assign go_div   = 1'b0;
  assign div_st   = 1'b0;
  assign step_bit = op_b[cnt];
`endif
  muldiv_iter_step u_step (
    .div(div_st),
    .acc(acc),
    .mag(div_st ? op_b : op_a),
    .bit_in(step_bit),
    .acc_next(acc_step)
  );
  assign prod    = (sa ^ sb) ? -acc : acc;
  assign mul_res = op == OP_MADD ? {Hi, Lo} + prod : op == OP_MSUB ? {Hi, Lo} - prod : prod;
`ifdef MULDIV_DIV_EN
  // a zero divisor keeps the all-ones quotient regardless of operand signs
  assign res = op[2] ? {(sa ? -acc[63:32] : acc[63:32]),
                        ((sa ^ sb) && op_b != 32'd0 ? -acc[31:0] : acc[31:0])} : mul_res;
`else
  assign res = mul_res;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: state_nx = go_mul ? S_MUL : go_div ? S_DIV : S_IDLE;
      S_MUL:  state_nx = cnt == 5'(ITER_CNT - 1) ? S_FIX : S_MUL;
`ifdef MULDIV_DIV_EN
      S_DIV:  state_nx = cnt == 5'(ITER_CNT - 1) ? S_FIX : S_DIV;
`endif
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      op    <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      Hi    <= '0;
      Lo    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE) begin
        if (go_mul || go_div) begin
          op_a <= abs32(A, sgn & A[31]);
          op_b <= abs32(B, sgn & B[31]);
          sa   <= sgn & A[31];
          sb   <= sgn & B[31];
          op   <= Op;
          acc  <= '0;
          cnt  <= '0;
        end
        if (Start && Op == OP_MTHI) Hi <= A;
        if (Start && Op == OP_MTLO) Lo <= A;
      end else if (state == S_FIX) begin
        {Hi, Lo} <= res;
      end else begin
        acc <= acc_step;
        cnt <= cnt + 5'd1;
      end
    end
  end
  assign ReadData = ReadSel ? Hi : Lo;
  assign Busy     = state != S_IDLE;
  assign Stall    = Busy & (Start | ReadReq);
  assign Done     = state == S_FIX;
endmodule

// File: tb/tb_hi_lo_muldiv_seq.sv
// tb_hi_lo_muldiv_seq: directed self-checking bench for hi_lo_muldiv_seq
module tb_hi_lo_muldiv_seq;
  logic        Clk = 1'b0, Reset = 1'b1, Start = 1'b0, ReadReq = 1'b0, ReadSel = 1'b0;
  logic [2:0]  Op = 3'b000;
  logic [31:0] A = '0, B = '0;
  logic [31:0] ReadData, Hi, Lo;
  logic        Busy, Stall, Done;
  int checks = 0, errors = 0;
  hi_lo_muldiv_seq dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .ReadReq(ReadReq), .ReadSel(ReadSel), .ReadData(ReadData),
    .Busy(Busy), .Stall(Stall), .Done(Done), .Hi(Hi), .Lo(Lo)
  );
  always #5 Clk = ~Clk;

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic rr, input int inject,
                        output int dcyc, output int ndone, output int nstall, output int nbusy);
    dcyc = 0; ndone = 0; nstall = 0; nbusy = 0;
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b; ReadReq = rr;
    for (int n = 1; n <= 40; n++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (n == 34) ReadReq = 1'b0;
      if (n == inject) begin Start = 1'b1; Op = 3'b000; A = 32'd5; B = 32'd7; end
      #1;
      if (Done) begin ndone++; dcyc = n + 1; end
      if (Stall) nstall++;
      if (Busy) nbusy++;
    end
  endtask

  task automatic move_to(input logic [2:0] op, input logic [31:0] a);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a;
    @(negedge Clk);
    Start = 1'b0;
    #1;
    checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL mt_flags: busy=%b done=%b required 0 0", Busy, Done); end
  endtask

  task automatic test_reset;
    Start = 1'b1; ReadReq = 1'b1; Op = 3'b100; A = 32'hDEAD_BEEF;
    repeat (2) @(negedge Clk);
    checks++; if (Hi !== 32'd0 || Lo !== 32'd0) begin errors++; $display("FAIL reset_hilo: %h_%h required 0_0", Hi, Lo); end
    checks++; if ({Busy, Stall, Done} !== 3'b000) begin errors++; $display("FAIL reset_flags: %b required 000", {Busy, Stall, Done}); end
    Start = 1'b0; ReadReq = 1'b0; Reset = 1'b0;
  endtask

  task automatic test_mult;
    int dc, nd, ns, nb;
    run_op(3'b000, 32'hFFFF_FFFE, 32'd3, 1'b0, 0, dc, nd, ns, nb);
    checks++; if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL mult_neg: %h_%h required ffffffff_fffffffa", Hi, Lo); end
    checks++; if (nd !== 1 || dc !== 34) begin errors++; $display("FAIL mult_done: pulses=%0d cycle=%0d required 1 at 34", nd, dc); end
    checks++; if (nb !== 33) begin errors++; $display("FAIL mult_busy: %0d busy cycles required 33", nb); end
    run_op(3'b000, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, dc, nd, ns, nb);
    checks++; if ({Hi, Lo} !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL mult_minint: %h_%h required 40000000_00000000", Hi, Lo); end
    run_op(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 0, dc, nd, ns, nb);
    checks++; if ({Hi, Lo} !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL multu: %h_%h required 00000001_fffffffe", Hi, Lo); end
  endtask

  task automatic test_madd_msub;
    int dc, nd, ns, nb;
    move_to(3'b100, 32'd0);
    move_to(3'b101, 32'd10);
    checks++; if (Hi !== 32'd0 || Lo !== 32'd10) begin errors++; $display("FAIL mthi_mtlo: %h_%h required 0_a", Hi, Lo); end
    run_op(3'b010, 32'd4, 32'd5, 1'b0, 0, dc, nd, ns, nb);
    checks++; if (Hi !== 32'd0 || Lo !== 32'd30) begin errors++; $display("FAIL madd: %h_%h required 0_1e", Hi, Lo); end
    run_op(3'b011, 32'd31, 32'd1, 1'b0, 0, dc, nd, ns, nb);
    checks++; if (Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL msub_wrap: %h_%h required ffffffff_ffffffff", Hi, Lo); end
  endtask

  task automatic test_stall_read;
    int dc, nd, ns, nb;
    run_op(3'b000, 32'h0001_0000, 32'h0001_0000, 1'b1, 0, dc, nd, ns, nb);
    checks++; if (ns !== 33) begin errors++; $display("FAIL stall_cycles: %0d required 33", ns); end
    ReadSel = 1'b1; #1;
    checks++; if (ReadData !== 32'd1) begin errors++; $display("FAIL read_hi: %h required 1", ReadData); end
    ReadSel = 1'b0; #1;
    checks++; if (ReadData !== 32'd0) begin errors++; $display("FAIL read_lo: %h required 0", ReadData); end
  endtask

  task automatic test_div;
    int dc, nd, ns, nb;
`ifdef MULDIV_DIV_EN
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, dc, nd, ns, nb);
    checks++; if (Lo !== 32'hFFFF_FFFD || Hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg: %h_%h required ffffffff_fffffffd", Hi, Lo); end
    checks++; if (nd !== 1 || dc !== 34) begin errors++; $display("FAIL div_done: pulses=%0d cycle=%0d required 1 at 34", nd, dc); end
    run_op(3'b111, 32'd7, 32'd0, 1'b0, 0, dc, nd, ns, nb);
    checks++; if (Hi !== 32'd7 || Lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero: %h_%h required 7_ffffffff", Hi, Lo); end
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, dc, nd, ns, nb);
    checks++; if (Hi !== 32'd0 || Lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf: %h_%h required 0_80000000", Hi, Lo); end
`else
    move_to(3'b100, 32'h1111_2222);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, dc, nd, ns, nb);
    checks++; if (nb !== 0 || nd !== 0) begin errors++; $display("FAIL div_off_flags: busy=%0d done=%0d required 0 0", nb, nd); end
    checks++; if (Hi !== 32'h1111_2222 || Lo !== 32'd0) begin errors++; $display("FAIL div_off_hilo: %h_%h required 11112222_0", Hi, Lo); end
`endif
  endtask

  task automatic test_reset_abort;
    int nd = 0;
    move_to(3'b100, 32'h0000_1234);
    move_to(3'b101, 32'h0000_5678);
    @(negedge Clk);
    Start = 1'b1; Op = 3'b001; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    for (int n = 1; n <= 10; n++) begin
      @(negedge Clk);
      Start = 1'b0;
    end
    Reset = 1'b1; #1;
    checks++; if ({Busy, Done} !== 2'b00) begin errors++; $display("FAIL abort_busy: busy=%b done=%b required 0 0", Busy, Done); end
    checks++; if (Hi !== 32'd0 || Lo !== 32'd0) begin errors++; $display("FAIL abort_hilo: %h_%h required 0_0", Hi, Lo); end
    @(negedge Clk);
    Reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge Clk); #1;
      if (Done) nd++;
    end
    checks++; if (nd !== 0 || Hi !== 32'd0 || Lo !== 32'd0) begin errors++; $display("FAIL abort_after: done=%0d hilo=%h_%h required 0 0_0", nd, Hi, Lo); end
  endtask

  task automatic test_busy_ignore;
    int dc, nd, ns, nb;
    run_op(3'b000, 32'd6, 32'hFFFF_FFFD, 1'b0, 5, dc, nd, ns, nb);
    checks++; if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFEE) begin errors++; $display("FAIL ignore_result: %h_%h required ffffffff_ffffffee", Hi, Lo); end
    checks++; if (nd !== 1 || ns !== 1) begin errors++; $display("FAIL ignore_flags: done=%0d stall=%0d required 1 1", nd, ns); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_madd_msub();
    test_stall_read();
    test_div();
    test_reset_abort();
    test_busy_ignore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
